// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle LEGv8 control FSM sharing one memory port
// between instruction fetch and LDUR/STUR data accesses.
// Optional build macro: HALT_ON_ILLEGAL_EN -- when defined, an illegal opcode
// parks the FSM in HALT until reset; otherwise it retires as a NOP.
module multicycle_sequencer #(
  parameter int MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        regwrite,
  output logic        mem2reg,
  output logic        retire,
  output logic        fault,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ILL, C_R, C_I, C_MOVZ, C_LDUR, C_STUR, C_CBZ, C_B
  } cls_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state, state_n;
  cls_t       cls, dec_cls;
  logic [7:0] wait_cnt;
  logic       req_raw, timeout;

  // casez is first-match, so the item order encodes the decode priority
  function automatic cls_t decode(input logic [10:0] op);
    casez (op)
      11'b??111000010: decode = C_LDUR;
      11'b??111000000: decode = C_STUR;
      11'b?0001010???,
      11'b?0101010???,
      11'b?0?01011???,
      11'b?1?01011???: decode = C_R;
      11'b?011010????: decode = C_CBZ;
      11'b?00101?????: decode = C_B;
      11'b?0?10001???,
      11'b?1?10001???: decode = C_I;
      11'b110100101??: decode = C_MOVZ;
      default:         decode = C_ILL;
    endcase
  endfunction

  assign dec_cls = decode(opcode);
  // Request intent of the state, independent of reset masking, drives the timeout
  assign req_raw = (state == S_FETCH) || (state == S_MEM);
  assign timeout = req_raw && !mem_ack && (wait_cnt == WAIT_LAST);

  // State register
  always_ff @(posedge CLK) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  // Instruction class is captured once in DECODE and used by EXEC/MEM/WB
  always_ff @(posedge CLK) begin
    if (reset)                   cls <= C_ILL;
    else if (state == S_DECODE)  cls <= dec_cls;
  end

  // Consecutive unacknowledged request cycles; restarts on ack or state change
  always_ff @(posedge CLK) begin
    if (reset || !req_raw || mem_ack || (state_n != state)) wait_cnt <= '0;
    else                                                    wait_cnt <= wait_cnt + 8'd1;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_FETCH: begin
        if (timeout)      state_n = S_FAULT;
        else if (mem_ack) state_n = S_DECODE;
      end
      S_DECODE: begin
        if (dec_cls == C_ILL) begin
`ifdef HALT_ON_ILLEGAL_EN
          state_n = S_HALT;
`else
          state_n = S_FETCH;
`endif
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_B, C_CBZ:     state_n = S_FETCH;
          C_LDUR, C_STUR: state_n = S_MEM;
          default:        state_n = S_WB;
        endcase
      end
      S_MEM: begin
        if (timeout)      state_n = S_FAULT;
        else if (mem_ack) state_n = (cls == C_LDUR) ? S_WB : S_FETCH;
      end
      S_WB:    state_n = S_FETCH;
      S_FAULT: state_n = S_FAULT;
`ifdef HALT_ON_ILLEGAL_EN
      S_HALT:  state_n = S_HALT;
`endif
      default: state_n = S_FETCH;
    endcase
  end

  // Output decode; everything except the debug state is masked during reset
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    regwrite     = 1'b0;
    mem2reg      = 1'b0;
    retire       = 1'b0;
    fault        = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ack;
          pc_write = mem_ack;
        end
        S_DECODE: begin
`ifndef HALT_ON_ILLEGAL_EN
          retire = (dec_cls == C_ILL);
`endif
        end
        S_EXEC: begin
          if (cls == C_B) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            retire   = 1'b1;
          end else if (cls == C_CBZ) begin
            pc_write = zero;
            pc_src   = 1'b1;
            retire   = 1'b1;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (cls == C_STUR);
          retire       = mem_ack && (cls == C_STUR);
        end
        S_WB: begin
          regwrite = 1'b1;
          mem2reg  = (cls == C_LDUR);
          retire   = 1'b1;
        end
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_o = state;

endmodule
